// File: rtl/upg_pkg.sv
// Shared types and constants for the UART instruction-memory loader.
// Loader FSM states, receiver states, and framing constants.
package upg_pkg;

  localparam int UART_DATA_BITS   = 8;
  localparam int DEF_CLKS_PER_BIT = 78;

  typedef enum logic [2:0] {
    CNT_LO,
    CNT_HI,
    DATA,
    DONE,
    ERR
  } upg_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_BITS,
    RX_STOP
  } rx_state_e;

endpackage

// File: rtl/upg_uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampler, shift register.
// Emits a one-cycle byte_valid_o or frame_err_o after the stop bit.
module upg_uart_rx
  import upg_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_o
);

  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int HALF = CLKS_PER_BIT / 2;

  rx_state_e    state_q;
  logic         sync1_q;
  logic         sync2_q;
  logic         prev_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]   bit_q;
  logic [7:0]   shift_q;
  logic         valid_q;
  logic         ferr_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      unique case (state_q)
        RX_IDLE: begin
          if (prev_q && !sync2_q) begin
            state_q <= RX_START;
            cnt_q   <= '0;
          end
        end
        RX_START: begin
          // Line must still be low half a bit later, else it was a glitch.
          if (cnt_q == CW'(HALF - 1)) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            state_q <= sync2_q ? RX_IDLE : RX_BITS;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RX_BITS: begin
          if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
            cnt_q   <= '0;
            shift_q <= {sync2_q, shift_q[7:1]};
            bit_q   <= bit_q + 1'b1;
            if (bit_q == 3'(UART_DATA_BITS - 1)) begin
              state_q <= RX_STOP;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
            cnt_q   <= '0;
            state_q <= RX_IDLE;
            valid_q <= sync2_q;
            ferr_q  <= !sync2_q;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

  assign byte_o       = shift_q;
  assign byte_valid_o = valid_q;
  assign frame_err_o  = ferr_q;

endmodule

// File: rtl/upg_uart_loader.sv
// Header + word assembly FSM driving the instruction-memory programming port.
// Stream: 16-bit LE word count N, then N little-endian 32-bit words.
module upg_uart_loader
  import upg_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int ADDR_W       = 14
) (
  input  logic              upg_clk_i,
  input  logic              upg_rst_i,
  input  logic              rx_i,
  output logic              upg_wen_o,
  output logic [ADDR_W-1:0] upg_adr_o,
  output logic [31:0]       upg_dat_o,
  output logic              upg_done_o,
  output logic              err_o
);

  localparam logic [31:0] MAX_N = 32'd1 << ADDR_W;

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_ferr;

  upg_uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk_i       (upg_clk_i),
    .rst_i       (upg_rst_i),
    .rx_i        (rx_i),
    .byte_o      (rx_byte),
    .byte_valid_o(rx_valid),
    .frame_err_o (rx_ferr)
  );

  upg_state_e        state_q;
  logic [15:0]       cnt_q;
  logic [1:0]        lane_q;
  logic [31:0]       word_q;
  logic [ADDR_W-1:0] adr_q;
  logic [31:0]       dat_q;
  logic              wen_q;
  logic              done_q;
  logic              err_q;

  logic [15:0] n_hdr;
  logic [31:0] word_nxt;
  logic        adr_last;

  always_comb begin
    n_hdr    = {rx_byte, cnt_q[7:0]};
    word_nxt = {rx_byte, word_q[31:8]};
    adr_last = (32'(adr_q) + 32'd1) == 32'(cnt_q);
  end

  always_ff @(posedge upg_clk_i) begin
    if (upg_rst_i) begin
      state_q <= CNT_LO;
      cnt_q   <= '0;
      lane_q  <= '0;
      word_q  <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      wen_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      wen_q <= 1'b0;
      unique case (state_q)
        CNT_LO: begin
          if (rx_ferr) begin
            state_q <= ERR;
            err_q   <= 1'b1;
          end else if (rx_valid) begin
            cnt_q[7:0] <= rx_byte;
            state_q    <= CNT_HI;
          end
        end
        CNT_HI: begin
          if (rx_ferr) begin
            state_q <= ERR;
            err_q   <= 1'b1;
          end else if (rx_valid) begin
            cnt_q <= n_hdr;
            if (n_hdr == 16'd0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else if (32'(n_hdr) > MAX_N) begin
              state_q <= ERR;
              err_q   <= 1'b1;
            end else begin
              state_q <= DATA;
            end
          end
        end
        DATA: begin
          if (rx_ferr) begin
            state_q <= ERR;
            err_q   <= 1'b1;
          end else begin
            if (rx_valid) begin
              word_q <= word_nxt;
              lane_q <= lane_q + 1'b1;
              if (lane_q == 2'd3) begin
                wen_q <= 1'b1;
                dat_q <= word_nxt;
              end
            end
            // Last word finishes before the address could wrap.
            if (wen_q) begin
              if (adr_last) begin
                state_q <= DONE;
                done_q  <= 1'b1;
              end else begin
                adr_q <= adr_q + 1'b1;
              end
            end
          end
        end
        DONE: ;
        ERR:  ;
        default: begin
          state_q <= ERR;
          err_q   <= 1'b1;
        end
      endcase
    end
  end

  assign upg_wen_o  = wen_q;
  assign upg_adr_o  = adr_q;
  assign upg_dat_o  = dat_q;
  assign upg_done_o = done_q;
  assign err_o      = err_q;

endmodule

// File: doc/upg_uart_loader.md
Name: upg_uart_loader

Overview:
- Writer side of the instruction-memory programming port.
- Receives a UART byte stream from the host, assembles it into 32-bit little-endian words, and drives the upg write interface (write-enable, word address, data, done) that IFetch consumes.
- Lives in the upg clock domain, in front of the instruction RAM's programming port.

Parameters:
- CLKS_PER_BIT, 78, upg clock cycles per UART bit (10 MHz / 128000 baud); must be >= 4.
- ADDR_W, 14, word-address width of the programming port.

Ports:
- upg_clk_i  input  1  programming clock; all logic on its rising edge.
- upg_rst_i  input  1  synchronous, active-high reset.
- rx_i  input  1  UART serial line, idle high, 8N1, LSB first; asynchronous to upg_clk_i.
- upg_wen_o  output  1  one-cycle write strobe to instruction memory.
- upg_adr_o  output  ADDR_W  word address, valid while upg_wen_o=1.
- upg_dat_o  output  32  instruction word, valid while upg_wen_o=1.
- upg_done_o  output  1  sticky, set when the full image has been written.
- err_o  output  1  sticky, set on a framing or length error.

Behaviour:
- Reset: every output is 0. FSM goes to CNT_LO, byte-lane counter to 0, uart_rx to idle.
- Reset mid-transfer discards partial words and the header; the next byte is read as a new header.
- Stream format:
  - Header: 2-byte word count N, little-endian.
  - Payload: 4*N bytes, each word little-endian (first byte = bits 7:0).
  - Word k is written to address k, for k = 0..N-1.
- rx_i passes through a 2-flop synchronizer before any use.
- uart_rx operation:
  - Falling edge starts a frame; the line is rechecked at CLKS_PER_BIT/2. If high, it is a glitch and the receiver returns to idle.
  - Data bits are sampled every CLKS_PER_BIT, centred in the bit.
  - The stop bit is sampled at its centre, then one-cycle byte_valid (stop=1) or frame_err (stop=0) is raised.
- FSM states:
  - CNT_LO: on byte_valid, store N[7:0]; go to CNT_HI.
  - CNT_HI: on byte_valid, store N[15:8].
    - N=0: go to DONE.
    - N > 2^ADDR_W: go to ERR.
    - Otherwise go to DATA.
  - DATA: each byte_valid shifts into lane 0..3.
    - On lane 3, the cycle after byte_valid: upg_wen_o=1 for exactly one cycle, with upg_dat_o = assembled word and upg_adr_o = current address.
    - The following cycle, the address increments. If that write was word N-1, go to DONE.
  - DONE: upg_done_o=1 and held; all further bytes ignored; upg_wen_o stays 0.
  - ERR: err_o=1 and held; no writes; upg_done_o stays 0. Only upg_rst_i exits.
- frame_err in any state except DONE sends the FSM to ERR. A byte with a framing error never enters the data path.
- upg_adr_o holds its last value between strobes. upg_dat_o holds the last written word. Consumers must qualify both with upg_wen_o.
- Address N-1 = 2^ADDR_W - 1 is legal. The address register does not wrap, because DONE is entered first.
- Minimum spacing between strobes is 4 UART frames. The memory is never written two cycles in a row.

Decomposition:
- Shared package upg_pkg:
  - FSM state encoding (CNT_LO, CNT_HI, DATA, DONE, ERR).
  - UART_DATA_BITS = 8.
  - Default CLKS_PER_BIT.
- One sub-module, upg_uart_rx: synchronizer, bit timer, and shift register. Outputs byte_o[7:0], byte_valid_o, frame_err_o.
- The top level holds only the header and assembly FSM.

Test Plan (CLKS_PER_BIT=4 for simulation speed):
- Header 02 00, then bytes 78 56 34 12 EF BE AD DE -> strobes at adr 0 dat 0x12345678 and adr 1 dat 0xDEADBEEF, each exactly 1 cycle wide; upg_done_o=1 after the second strobe; err_o=0.
- Header 00 00 -> no strobe; upg_done_o=1 one cycle after the second header byte.
- Header 01 00, 2 payload bytes, upg_rst_i pulsed for 1 cycle, then header 01 00 with AA BB CC DD -> single strobe at adr 0 dat 0xDDCCBBAA; no strobe from the aborted transfer.
- Header 01 00, then a frame with stop bit 0 -> err_o=1 (sticky), upg_done_o=0, no strobes; later valid bytes are ignored.
- 1-cycle low glitch on rx_i while idle -> no byte_valid; a following header 01 00 plus 4 bytes still yields one correct strobe.
- After DONE from the first scenario, send 4 more bytes -> upg_wen_o stays 0 and upg_adr_o stays 1.
